add32_seq: RTL and testbench

- 32-bit sequential adder built around a single adder_16bit instance, time-multiplexed over two cycles.
- Adds the low halves first, then the high halves using the registered carry from the low half.
- Sits directly upstream of the 16-bit adder: it registers the operands, sequences the two adder passes and captures the adder's outputs.
- Presents a valid/ready handshake on both its input and output sides.

---
 rtl/add32_seq.sv | 143 ++++++++++++++
 tb/tb_add32_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/add32_seq.sv
// 32-bit adder that reuses one 16-bit adder over two cycles: the low half first, then the high half.
// The block has a valid/ready handshake on both sides, and every output comes straight from a register.

module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

// state | meaning
// IDLE  | in_ready high, waiting to latch operands
// LO    | adder works on the low halves with cin_r; the carry is registered
// HI    | adder works on the high halves with carry_r; cout and ovf are captured
// DONE  | out_valid high; result held until out_ready
module add32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_cin;
    logic        r_carry;
    logic [31:0] r_sum;
    logic        r_cout;
    logic        r_ovf;

    logic [15:0] w_add_a;
    logic [15:0] w_add_b;
    logic        w_add_cin;
    logic [15:0] w_add_s;
    logic        w_add_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_LO;
                end
            end
            S_LO: w_state_nxt = S_HI;
            S_HI: w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The adder is fed only from registers, so no input port reaches an output combinationally.
    always_comb begin
        w_add_a   = r_a[31:16];
        w_add_b   = r_b[31:16];
        w_add_cin = r_carry;
        if (r_state == S_LO) begin
            w_add_a   = r_a[15:0];
            w_add_b   = r_b[15:0];
            w_add_cin = r_cin;
        end
    end

    adder_16bit u_adder (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (w_add_cin),
        .s    (w_add_s),
        .cout (w_add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= 32'd0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cin <= cin;
                    end
                end
                S_LO: begin
                    r_sum[15:0] <= w_add_s;
                    r_carry     <= w_add_cout;
                end
                S_HI: begin
                    r_sum[31:16] <= w_add_s;
                    r_cout       <= w_add_cout;
                    r_ovf        <= (r_a[31] == r_b[31]) & (w_add_s[15] != r_a[31]);
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_add32_seq.sv
// Self-checking bench for add32_seq: a vector table, random operations checked against an arithmetic model,
// and hand-written reset, backpressure and abort sequences.

module tb_add32_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    add32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain 33-bit unsigned sum and a signed range test.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                         output logic [31:0] ms, output logic mco, output logic mo);
        longint unsigned u;
        longint          s;
        u   = longint'({32'd0, ma}) + longint'({32'd0, mb}) + longint'(mc);
        ms  = u[31:0];
        mco = u[32];
        s   = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
        mo  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endtask

    // Waits for out_valid (bounded) and returns the number of edges since the caller's reference edge.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                          input logic [31:0] es, input logic ec, input logic eo, input string name);
        int cyc;
        @(negedge clk);
        chk({name, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        wait_valid(cyc);
        chk({name, ".latency"}, 32'(cyc), 32'd2);
        chk({name, ".sum"}, sum, es);
        chk({name, ".cout"}, 32'(cout), 32'(ec));
        chk({name, ".ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
        chk({name, ".in_ready_post"}, 32'(in_ready), 32'd1);
        chk({name, ".out_valid_post"}, 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] ms;
        logic        mco;
        logic        mo;
        int          cyc;

        vecs.push_back('{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.sum", sum, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = ~ra;
            model(ra, rb, rc, ms, mco, mo);
            run_op(ra, rb, rc, ms, mco, mo, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset between clock edges while a nonzero result is held in DONE.
        @(negedge clk);
        a = 32'hFFFF0000; b = 32'h0000FFFF; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("async.sum_before", sum, 32'hFFFFFFFF);
        #2 rst = 1'b1;
        #1;
        chk("async.in_ready", 32'(in_ready), 32'd1);
        chk("async.out_valid", 32'(out_valid), 32'd0);
        chk("async.sum", sum, 32'd0);
        chk("async.cout_ovf", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Backpressure: hold DONE for 5 cycles while a new operation is offered.
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("bp.latency", 32'(cyc), 32'd2);
        @(negedge clk);
        a = 32'h00000100; b = 32'h00000023; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.sum%0d", i), sum, 32'h23456789);
            chk($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp.out_valid%0d", i), 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp.idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp.accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("bp.new_latency", 32'(cyc), 32'd2);
        chk("bp.new_sum", sum, 32'h00000124);
        @(posedge clk); #1;

        // Abort in HI: no out_valid may follow, and the next operation must work normally.
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort.out_valid_now", 32'(out_valid), 32'd0);
        chk("abort.sum", sum, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("abort.out_valid%0d", i), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        run_op(32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
